// File: rtl/vertex_transform.sv
// Vertex transform stage: shadows a streamed 4x4 view-projection matrix and maps
// object-space vertices to homogeneous clip space with a pipelined fp32 dot unit.

// Four-term binary32 dot product, three register stages, in-order, fixed latency.
// Denormal inputs flush to zero; exponent overflow saturates to infinity.
module fp32_dot (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [3:0][31:0] a_in,
    input  logic [3:0][31:0] b_in,
    output logic             valid_out,
    output logic [31:0]      c_out
);
    logic               v1, v2;
    logic [3:0]         p_sign;
    logic [3:0][9:0]    p_exp;
    logic [3:0][47:0]   p_mant;
    logic [9:0]         s_exp;
    logic signed [50:0] s_sum;

    logic [9:0]         emax;
    logic signed [50:0] term, sum;
    logic [50:0]        mag;
    logic [5:0]         msb;
    logic [22:0]        frac;
    logic signed [11:0] rexp;
    logic [31:0]        res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            valid_out <= 1'b0;
            p_sign    <= '0;
            p_exp     <= '0;
            p_mant    <= '0;
            s_exp     <= '0;
            s_sum     <= '0;
            c_out     <= '0;
        end else begin
            v1        <= valid_in;
            v2        <= v1;
            valid_out <= v2;
            for (int k = 0; k < 4; k++) begin
                p_sign[k] <= a_in[k][31] ^ b_in[k][31];
                if (a_in[k][30:23] == 8'd0 || b_in[k][30:23] == 8'd0) begin
                    p_exp[k]  <= '0;
                    p_mant[k] <= '0;
                end else begin
                    p_exp[k]  <= {2'b00, a_in[k][30:23]} + {2'b00, b_in[k][30:23]};
                    p_mant[k] <= {24'd0, 1'b1, a_in[k][22:0]} * {24'd0, 1'b1, b_in[k][22:0]};
                end
            end
            s_exp <= emax;
            s_sum <= sum;
            c_out <= res;
        end
    end

    // Align every product to the largest exponent, then accumulate signed.
    always_comb begin
        emax = '0;
        for (int k = 0; k < 4; k++)
            if (p_exp[k] > emax) emax = p_exp[k];
        sum  = '0;
        term = '0;
        for (int k = 0; k < 4; k++) begin
            term = $signed({3'b000, p_mant[k] >> (emax - p_exp[k])});
            sum  = p_sign[k] ? sum - term : sum + term;
        end
    end

    // A product of two 1.23 mantissas carries its binary point at bit 46,
    // so the biased result exponent is msb + (ea + eb) - 254 - 46 + 127.
    always_comb begin
        mag  = s_sum[50] ? -s_sum : s_sum;
        msb  = '0;
        for (int j = 0; j < 50; j++)
            if (mag[j]) msb = 6'(j);
        frac = 23'((mag[49:0] << (6'd49 - msb)) >> 26);
        rexp = $signed({2'b00, s_exp}) + $signed({6'd0, msb}) - 12'sd173;
        if (mag == '0 || rexp <= 0)
            res = '0;
        else if (rexp >= 12'sd255)
            res = {s_sum[50], 8'hFF, 23'd0};
        else
            res = {s_sum[50], rexp[7:0], frac};
    end
endmodule

module vertex_transform #(
    parameter logic [31:0] FP_ONE = 32'h3F800000
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             mat_valid_in,
    input  logic [3:0][31:0] mat_col_in,
    output logic             matrix_loaded_out,
    input  logic             vertex_valid_in,
    output logic             vertex_ready_out,
    input  logic [2:0][31:0] vertex_in,
    output logic             clip_valid_out,
    input  logic             clip_ready_in,
    output logic [3:0][31:0] clip_out,
    output logic [1:0]       fsm_state
);
    typedef enum logic [1:0] {IDLE, ISSUE, COLLECT, OUTPUT} state_t;

    state_t                state, next;
    logic [3:0][3:0][31:0] shadow;  // shadow[column][row]
    logic [3:0][3:0][31:0] rows;    // active matrix, rows[row][column]
    logic [3:0][31:0]      vtx, result;
    logic [1:0]            col_cnt, idx, res_cnt;
    logic                  pending, ready, accept, commit;
    logic                  dot_valid, dot_out_valid;
    logic [31:0]           dot_out;

    assign vertex_ready_out = ready;
    assign fsm_state        = state;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= next;
    end

    // vertex_* and clip_* ports: a transfer happens on the rising clk_in edge
    // where valid and ready are both high; a raised valid holds its data until then.
    always_comb begin
        next      = state;
        ready     = 1'b0;
        accept    = 1'b0;
        commit    = 1'b0;
        dot_valid = 1'b0;
        case (state)
            IDLE: begin
                commit = pending && !mat_valid_in;
                ready  = matrix_loaded_out && !pending;
                accept = vertex_valid_in && ready;
                if (accept) next = ISSUE;
            end
            ISSUE: begin
                dot_valid = 1'b1;
                if (idx == 2'd3) next = COLLECT;
            end
            COLLECT: if (dot_out_valid && res_cnt == 2'd3) next = OUTPUT;
            OUTPUT:  if (clip_valid_out && clip_ready_in) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            shadow            <= '0;
            rows              <= '0;
            col_cnt           <= '0;
            pending           <= 1'b0;
            matrix_loaded_out <= 1'b0;
            vtx               <= '0;
            idx               <= '0;
            res_cnt           <= '0;
            result            <= '0;
            clip_valid_out    <= 1'b0;
            clip_out          <= '0;
        end else begin
            if (mat_valid_in) begin
                shadow[col_cnt] <= mat_col_in;
                col_cnt         <= col_cnt + 2'd1;
                if (col_cnt == 2'd3) pending <= 1'b1;
            end
            if (commit) begin
                for (int r = 0; r < 4; r++)
                    for (int k = 0; k < 4; k++)
                        rows[r][k] <= shadow[k][r];
                pending           <= 1'b0;
                matrix_loaded_out <= 1'b1;
            end
            if (accept) begin
                vtx     <= {FP_ONE, vertex_in[2], vertex_in[1], vertex_in[0]};
                idx     <= '0;
                res_cnt <= '0;
            end
            if (dot_valid) idx <= idx + 2'd1;
            // Short dot latency can return early results while still issuing.
            if (dot_out_valid) begin
                result[res_cnt] <= dot_out;
                res_cnt         <= res_cnt + 2'd1;
            end
            if (state == OUTPUT) begin
                if (!clip_valid_out) begin
                    clip_out       <= result;
                    clip_valid_out <= 1'b1;
                end else if (clip_ready_in) begin
                    clip_valid_out <= 1'b0;
                end
            end
        end
    end

    fp32_dot u_dot (
        .clk       (clk_in),
        .rst       (rst_in),
        .valid_in  (dot_valid),
        .a_in      (rows[idx]),
        .b_in      (vtx),
        .valid_out (dot_out_valid),
        .c_out     (dot_out)
    );
endmodule

// File: tb/tb_vertex_transform.sv
// Bench for vertex_transform: integer-valued matrices and vertices so every clip
// component is exact in binary32; expectations come from an integer matrix model.
module tb_vertex_transform;
    localparam int DOT_LAT = 3;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             mat_valid_in;
    logic [3:0][31:0] mat_col_in;
    logic             matrix_loaded_out;
    logic             vertex_valid_in;
    logic             vertex_ready_out;
    logic [2:0][31:0] vertex_in;
    logic             clip_valid_out;
    logic             clip_ready_in;
    logic [3:0][31:0] clip_out;
    logic [1:0]       fsm_state;

    int           vectors = 0;
    int           miscompares = 0;
    logic [127:0] exp_q[$];
    int           next_m[4][4];
    int           model_m[4][4];

    vertex_transform dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .mat_valid_in      (mat_valid_in),
        .mat_col_in        (mat_col_in),
        .matrix_loaded_out (matrix_loaded_out),
        .vertex_valid_in   (vertex_valid_in),
        .vertex_ready_out  (vertex_ready_out),
        .vertex_in         (vertex_in),
        .clip_valid_out    (clip_valid_out),
        .clip_ready_in     (clip_ready_in),
        .clip_out          (clip_out),
        .fsm_state         (fsm_state)
    );

    // Clock and watchdog
    always #5 clk_in = ~clk_in;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: exact integer arithmetic, converted to binary32 at the end.
    function automatic logic [31:0] to_fp(input int v);
        int          a, e;
        logic [31:0] m;
        if (v == 0) return 32'h0;
        a = (v < 0) ? -v : v;
        e = 0;
        while ((a >> (e + 1)) != 0) e++;
        m = 32'(a) << (23 - e);
        return {v < 0, 8'(127 + e), m[22:0]};
    endfunction

    function automatic logic [127:0] model_clip(input int vx, input int vy, input int vz);
        int               v[4];
        int               acc;
        logic [3:0][31:0] r;
        v[0] = vx; v[1] = vy; v[2] = vz; v[3] = 1;
        for (int i = 0; i < 4; i++) begin
            acc = 0;
            for (int k = 0; k < 4; k++) acc += model_m[i][k] * v[k];
            r[i] = to_fp(acc);
        end
        return r;
    endfunction

    // Driver tasks
    task automatic set_identity();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                next_m[r][c] = (r == c) ? 1 : 0;
    endtask

    task automatic set_random();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                next_m[r][c] = int'($urandom_range(8)) - 4;
    endtask

    task automatic load_matrix();
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) mat_col_in[r] = to_fp(next_m[r][c]);
            mat_valid_in = 1'b1;
            @(negedge clk_in);
        end
        mat_valid_in = 1'b0;
        mat_col_in   = '0;
    endtask

    task automatic send_vertex(input int vx, input int vy, input int vz,
                               input logic [127:0] exp_clip, input int hold,
                               input bit chk_lat, input bit ready_after);
        int           lat;
        bit           ok;
        logic [127:0] held;
        vertex_in       = {to_fp(vz), to_fp(vy), to_fp(vx)};
        vertex_valid_in = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (vertex_ready_out) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
        check("accept", 128'(ok), 128'd1);
        if (!ok) begin
            vertex_valid_in = 1'b0;
            return;
        end
        exp_q.push_back(exp_clip);
        @(negedge clk_in);
        vertex_valid_in = 1'b0;
        lat = 0;
        while (!clip_valid_out && lat < 100) begin
            @(negedge clk_in);
            lat++;
        end
        check("clip_valid_timeout", 128'(clip_valid_out), 128'd1);
        if (!clip_valid_out) begin
            void'(exp_q.pop_front());
            return;
        end
        if (chk_lat) check("latency", 128'(lat), 128'(5 + DOT_LAT));
        held = clip_out;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_in);
            check("stall_data", clip_out, held);
            check("stall_valid", 128'(clip_valid_out), 128'd1);
            check("stall_ready", 128'(vertex_ready_out), 128'd0);
        end
        check("clip_out", clip_out, exp_q.pop_front());
        clip_ready_in = 1'b1;
        @(negedge clk_in);
        clip_ready_in = 1'b0;
        check("valid_drop", 128'(clip_valid_out), 128'd0);
        check("ready_after", 128'(vertex_ready_out), 128'(ready_after));
    endtask

    // Main sequence
    initial begin
        logic [127:0] exp_old;
        int           vx, vy, vz;
        rst_in          = 1'b1;
        mat_valid_in    = 1'b0;
        mat_col_in      = '0;
        vertex_valid_in = 1'b0;
        vertex_in       = '0;
        clip_ready_in   = 1'b0;
        repeat (2) @(negedge clk_in);
        check("rst_loaded", 128'(matrix_loaded_out), 128'd0);
        check("rst_ready", 128'(vertex_ready_out), 128'd0);
        check("rst_valid", 128'(clip_valid_out), 128'd0);
        check("rst_clip", clip_out, 128'd0);
        rst_in = 1'b0;

        // No matrix yet: vertex must never be accepted.
        vertex_in       = {to_fp(3), to_fp(2), to_fp(1)};
        vertex_valid_in = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_in);
            check("nomat_ready", 128'(vertex_ready_out), 128'd0);
            check("nomat_valid", 128'(clip_valid_out), 128'd0);
        end
        vertex_valid_in = 1'b0;

        // Identity matrix with a six-cycle downstream stall.
        set_identity();
        load_matrix();
        model_m = next_m;
        send_vertex(1, 2, 3, 128'h3F800000_40400000_40000000_3F800000, 6, 1'b1, 1'b1);
        check("loaded", 128'(matrix_loaded_out), 128'd1);

        // Translation by (1,2,3) applied to the origin.
        set_identity();
        next_m[0][3] = 1;
        next_m[1][3] = 2;
        next_m[2][3] = 3;
        load_matrix();
        model_m = next_m;
        send_vertex(0, 0, 0, 128'h3F800000_40400000_40000000_3F800000, 0, 1'b1, 1'b1);

        // New matrix streams in while a vertex is being computed.
        set_random();
        exp_old = model_clip(2, -3, 5);
        fork
            send_vertex(2, -3, 5, exp_old, 2, 1'b1, 1'b0);
            begin
                repeat (5) @(negedge clk_in);
                load_matrix();
            end
        join
        model_m = next_m;
        send_vertex(-1, 4, 2, model_clip(-1, 4, 2), 0, 1'b1, 1'b1);

        // Reset while issuing dot products.
        check("pre_rst_ready", 128'(vertex_ready_out), 128'd1);
        vertex_in       = {to_fp(1), to_fp(1), to_fp(1)};
        vertex_valid_in = 1'b1;
        @(negedge clk_in);
        vertex_valid_in = 1'b0;
        rst_in = 1'b1;
        #1;
        check("midrst_loaded", 128'(matrix_loaded_out), 128'd0);
        check("midrst_ready", 128'(vertex_ready_out), 128'd0);
        check("midrst_valid", 128'(clip_valid_out), 128'd0);
        check("midrst_clip", clip_out, 128'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            check("postrst_valid", 128'(clip_valid_out), 128'd0);
            check("postrst_loaded", 128'(matrix_loaded_out), 128'd0);
        end

        // Randomized matrices and vertices.
        for (int m = 0; m < 3; m++) begin
            set_random();
            load_matrix();
            model_m = next_m;
            for (int n = 0; n < 8; n++) begin
                vx = int'($urandom_range(16)) - 8;
                vy = int'($urandom_range(16)) - 8;
                vz = int'($urandom_range(16)) - 8;
                send_vertex(vx, vy, vz, model_clip(vx, vy, vz),
                            int'($urandom_range(3)), 1'b1, 1'b1);
            end
        end

        check("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
